// File: rtl/klt_roi_overlay.sv
// Box-outline overlay on a 24-bit RGB stream. Box position and enable are latched at frame start.
// Optional crosshair (inverted pixels) when KLT_OVERLAY_CROSSHAIR_EN is defined.
module klt_roi_overlay #(
  parameter int          BOX_HALF  = 16,
  parameter logic [23:0] BOX_COLOR = 24'hFF0000
) (
  input  logic        rx_pclk,
  input  logic        rx_rst,
  input  logic        rx_de,
  input  logic        rx_hsync,
  input  logic        rx_vsync,
  input  logic [23:0] pixel_in,
  input  logic [11:0] point_x,
  input  logic [10:0] point_y,
  input  logic        point_valid,
  input  logic        enable_overlay,
  output logic [23:0] pixel_out,
  output logic        de_out,
  output logic        hsync_out,
  output logic        vsync_out
);

  localparam logic signed [13:0] C_HALF = 14'(BOX_HALF);

  logic [11:0] r_x_cnt;
  logic [10:0] r_y_cnt;
  logic        r_de_d;
  logic        r_vs_d;
  logic [11:0] r_pend_x;
  logic [10:0] r_pend_y;
  logic        r_pend_ok;
  logic [11:0] r_act_x;
  logic [10:0] r_act_y;
  logic        r_act_ok;
  logic        r_act_en;
  logic        r_locked;
  logic [23:0] r_pixel_out;
  logic        r_de_out;
  logic        r_hsync_out;
  logic        r_vsync_out;

  logic               w_vs_rise;
  logic               w_de_fall;
  logic signed [13:0] w_x;
  logic signed [13:0] w_y;
  logic signed [13:0] w_ax;
  logic signed [13:0] w_ay;
  logic signed [13:0] w_l;
  logic signed [13:0] w_r;
  logic signed [13:0] w_t;
  logic signed [13:0] w_b;
  logic               w_qual;
  logic               w_hit;
  logic [23:0]        w_pix_next;

  assign w_vs_rise = rx_vsync & ~r_vs_d;
  assign w_de_fall = r_de_d & ~rx_de;

  assign w_x  = {2'b00, r_x_cnt};
  assign w_y  = {3'b000, r_y_cnt};
  assign w_ax = {2'b00, r_act_x};
  assign w_ay = {3'b000, r_act_y};
  assign w_l  = w_ax - C_HALF;
  assign w_r  = w_ax + C_HALF;
  assign w_t  = w_ay - C_HALF;
  assign w_b  = w_ay + C_HALF;

  // Counters are never negative, so off-frame edges simply never compare equal.
  assign w_qual = rx_de & r_locked & r_act_ok & r_act_en;
  assign w_hit  = w_qual &
                  ((((w_y == w_t) | (w_y == w_b)) & (w_x >= w_l) & (w_x <= w_r)) |
                   (((w_x == w_l) | (w_x == w_r)) & (w_y >= w_t) & (w_y <= w_b)));

`ifdef KLT_OVERLAY_CROSSHAIR_EN
  localparam logic signed [13:0] C_ARM = 14'(BOX_HALF / 2);

  logic signed [13:0] w_dx;
  logic signed [13:0] w_dy;
  logic signed [13:0] w_adx;
  logic signed [13:0] w_ady;
  logic               w_cross;

  assign w_dx    = w_x - w_ax;
  assign w_dy    = w_y - w_ay;
  assign w_adx   = (w_dx < 0) ? -w_dx : w_dx;
  assign w_ady   = (w_dy < 0) ? -w_dy : w_dy;
  assign w_cross = w_qual &
                   (((w_x == w_ax) & (w_ady <= C_ARM)) |
                    ((w_y == w_ay) & (w_adx <= C_ARM)));

  always_comb begin
    w_pix_next = pixel_in;
    if (w_hit)
      w_pix_next = BOX_COLOR;
    else if (w_cross)
      w_pix_next = ~pixel_in;
  end
`else
  assign w_pix_next = w_hit ? BOX_COLOR : pixel_in;
`endif

  always_ff @(posedge rx_pclk) begin
    if (rx_rst) begin
      r_x_cnt     <= '0;
      r_y_cnt     <= '0;
      r_de_d      <= 1'b0;
      r_vs_d      <= 1'b0;
      r_pend_x    <= '0;
      r_pend_y    <= '0;
      r_pend_ok   <= 1'b0;
      r_act_x     <= '0;
      r_act_y     <= '0;
      r_act_ok    <= 1'b0;
      r_act_en    <= 1'b0;
      r_locked    <= 1'b0;
      r_pixel_out <= '0;
      r_de_out    <= 1'b0;
      r_hsync_out <= 1'b0;
      r_vsync_out <= 1'b0;
    end else begin
      r_de_d <= rx_de;
      r_vs_d <= rx_vsync;

      r_x_cnt <= rx_de ? r_x_cnt + 12'd1 : 12'd0;
      if (w_vs_rise)
        r_y_cnt <= '0;
      else if (w_de_fall)
        r_y_cnt <= r_y_cnt + 11'd1;

      if (point_valid) begin
        r_pend_x  <= point_x;
        r_pend_y  <= point_y;
        r_pend_ok <= 1'b1;
      end

      // A strobe on the frame-start cycle bypasses pending so it shows in this frame.
      if (w_vs_rise) begin
        r_act_x  <= point_valid ? point_x : r_pend_x;
        r_act_y  <= point_valid ? point_y : r_pend_y;
        r_act_ok <= point_valid | r_pend_ok;
        r_act_en <= enable_overlay;
        r_locked <= 1'b1;
      end

      r_pixel_out <= w_pix_next;
      r_de_out    <= rx_de;
      r_hsync_out <= rx_hsync;
      r_vsync_out <= rx_vsync;
    end
  end

  assign pixel_out = r_pixel_out;
  assign de_out    = r_de_out;
  assign hsync_out = r_hsync_out;
  assign vsync_out = r_vsync_out;

endmodule

// File: doc/klt_roi_overlay.md
# klt_roi_overlay

Downstream stage of `klt_tracker`: draws a one-pixel box outline, centred on the tracked point, into the 24-bit RGB pixel stream before it reaches `hdmi_out`. Position updates from the tracker are buffered and applied only at frame start, so every output frame shows one stable box. Video passes through with one cycle of latency and unchanged sync timing.

## Interface
- `BOX_HALF`, 16: half side of the box in pixels, 1..255.
- `BOX_COLOR`, 24'hFF0000: outline colour, {R,G,B}.
- `rx_pclk` in 1: pixel clock, the only clock.
- `rx_rst` in 1: reset, synchronous and active-high.
- `rx_de` in 1: data enable, high on active pixels.
- `rx_hsync` in 1: horizontal sync, passed through only.
- `rx_vsync` in 1: vertical sync, active-high; a rising edge marks frame start.
- `pixel_in` in 24: {R,G,B} from the tracker.
- `point_x` in 12: tracked column.
- `point_y` in 11: tracked row.
- `point_valid` in 1: one-cycle strobe qualifying `point_x`/`point_y`.
- `enable_overlay` in 1: draw enable, sampled at frame start.
- `pixel_out` out 24: output pixel.
- `de_out`, `hsync_out`, `vsync_out` out 1 each: sync signals delayed to match `pixel_out`.

## Operation
- Counters:
  - `x_cnt` (12b) increments on each cycle with `rx_de` high and clears on any cycle with `rx_de` low.
  - `y_cnt` (11b) increments on each `rx_de` falling edge and clears on an `rx_vsync` rising edge.
  - Both counters wrap silently at their width.
- Position buffering:
  - `point_valid` loads the pending register (`pend_x`, `pend_y`) and sets `pend_ok`.
  - On an `rx_vsync` rising edge, pending is copied to active (`act_x`, `act_y`), `act_ok` <= `pend_ok`, and `act_en` <= `enable_overlay`.
  - If `point_valid` coincides with the `rx_vsync` rising edge, the new point goes straight to both pending and active.
- Frame lock: `locked` clears on reset and sets on the first `rx_vsync` rising edge. Nothing is drawn while `locked` is 0, because row counts are invalid mid-frame.
- Hit test, all arithmetic in signed 14b:
  - L = `act_x` − `BOX_HALF`, R = `act_x` + `BOX_HALF`, T = `act_y` − `BOX_HALF`, B = `act_y` + `BOX_HALF`.
  - `hit` = `rx_de` & `locked` & `act_ok` & `act_en` & (((`y_cnt` == T | `y_cnt` == B) & L ≤ `x_cnt` ≤ R) | ((`x_cnt` == L | `x_cnt` == R) & T ≤ `y_cnt` ≤ B)).
  - Edges that fall outside the frame (negative, or beyond the active area) never match, so the box clips naturally.
- Output register: `pixel_out` <= `hit` ? `BOX_COLOR` : `pixel_in`. `de_out`, `hsync_out` and `vsync_out` register their inputs.
- No handshake; the block never stalls or drops pixels.

## Timing
- Latency is exactly 1 cycle from each input signal to its output counterpart.
- Reset values: `pixel_out` = 0; `de_out` = `hsync_out` = `vsync_out` = 0; counters 0; pending and active registers 0; `pend_ok` = `act_ok` = `act_en` = `locked` = 0.
- Reset mid-frame: outputs show pass-through video from the first cycle after reset. No box appears until after the next `rx_vsync` rising edge that follows a `point_valid`.
- `enable_overlay` and position changes take effect only at frame start; there is no tearing within a frame.
- Multiple `point_valid` strobes in one frame: the last one wins.

## Configuration
- `KLT_OVERLAY_CROSSHAIR_EN` defined: also draws a crosshair.
  - Drawn pixels: (`x_cnt` == `act_x` & |`y_cnt` − `act_y`| ≤ `BOX_HALF`/2) or (`y_cnt` == `act_y` & |`x_cnt` − `act_x`| ≤ `BOX_HALF`/2).
  - Crosshair pixels output ~`pixel_in` (bitwise invert).
  - The crosshair is qualified by the same terms as `hit`. Where a pixel is on both the box and the crosshair, the box colour has priority.
- Not defined: only the box is drawn, and no crosshair logic is synthesised.

## Test plan
- Reset, then a 64x48 frame of constant 24'h101010 with no `point_valid` -> output equals input delayed 1 cycle; no `BOX_COLOR` pixels.
- `point_valid` with (32,24) and `BOX_HALF`=8 during frame 0 -> frame 0 unchanged. Frame 1 has 24'hFF0000 exactly at rows 16 and 32 for columns 24..40, and columns 24 and 40 for rows 16..32 (64 pixels total).
- Point (3,2), `BOX_HALF`=8 -> only edges R=11 and B=10 are drawn (clipped): column 11 for rows 0..10 and row 10 for columns 0..11.
- `point_valid` with (20,20) in the same cycle as the `rx_vsync` rising edge -> the box around (20,20) appears in the frame that starts at that edge.
- `enable_overlay` dropped mid-frame -> the rest of that frame still shows the box; the next frame is pure pass-through.
- `rx_rst` asserted mid-frame -> the following cycle `pixel_out` = 0. The rest of that frame is pass-through with no box, and drawing resumes only after a new `point_valid` plus a vsync.
